// File: rtl/half_life_pkg.sv
// Shared types and default widths for the half-life timer sequencer.
package half_life_pkg;

  localparam int CNT_W_DEF = 4;
  localparam int PER_W_DEF = 4;
  localparam int HL_W_DEF  = 3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT,
    DECAY,
    DONE
  } state_e;

endpackage

// File: rtl/half_life_sequencer.sv
// Half-life timer sequencer: loads the counter, then per expired period issues count-(count>>1) down pulses.
// All outputs registered (one cycle after the deciding input); no backpressure, ticks outside WAIT are dropped.
module half_life_sequencer
  import half_life_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int PER_W = PER_W_DEF,
  parameter int HL_W  = HL_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] init_val,
  input  logic [PER_W-1:0] period,
  input  logic             tick,
  output logic             cnt_load,
  output logic [CNT_W-1:0] cnt_in,
  output logic             cnt_down,
  output logic [CNT_W-1:0] count,
  output logic [HL_W-1:0]  halvings,
  output logic             busy,
  output logic             done
);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_in_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] rem_q;
  logic [PER_W-1:0] per_q;
  logic [PER_W-1:0] tick_q;
  logic [HL_W-1:0]  halv_q;
  logic             cnt_load_q;
  logic             cnt_down_q;
  logic             busy_q;
  logic             done_q;

  // The shadow follows exactly what the counter does with our strobes, so an
  // abort on a pulse cycle still accounts for that last pulse.
  always_comb begin
    count_d = count_q;
    if (cnt_load_q) begin
      count_d = cnt_in_q;
    end else if (cnt_down_q) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_in_q   <= '0;
      count_q    <= '0;
      rem_q      <= '0;
      per_q      <= '0;
      tick_q     <= '0;
      halv_q     <= '0;
      cnt_load_q <= 1'b0;
      cnt_down_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      count_q <= count_d;
      if (abort && (state_q != IDLE)) begin
        state_q    <= IDLE;
        cnt_load_q <= 1'b0;
        cnt_down_q <= 1'b0;
        done_q     <= 1'b0;
        busy_q     <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start && !abort) begin
              cnt_in_q   <= init_val;
              per_q      <= (period == '0) ? PER_W'(1) : period;
              tick_q     <= '0;
              cnt_load_q <= 1'b1;
              busy_q     <= 1'b1;
              state_q    <= LOAD;
            end
          end
          LOAD: begin
            cnt_load_q <= 1'b0;
            halv_q     <= '0;
            if (cnt_in_q == '0) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              state_q <= WAIT;
            end
          end
          WAIT: begin
            if (tick) begin
              if ((tick_q + PER_W'(1)) == per_q) begin
                tick_q     <= '0;
                rem_q      <= count_q - (count_q >> 1);
                cnt_down_q <= 1'b1;
                state_q    <= DECAY;
              end else begin
                tick_q <= tick_q + PER_W'(1);
              end
            end
          end
          DECAY: begin
            rem_q <= rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
              cnt_down_q <= 1'b0;
              if (halv_q != '1) begin
                halv_q <= halv_q + HL_W'(1);
              end
              // count_q is the pre-pulse value; 1 means this pulse empties the counter
              if (count_q == CNT_W'(1)) begin
                done_q  <= 1'b1;
                state_q <= DONE;
              end else begin
                state_q <= WAIT;
              end
            end
          end
          DONE: begin
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign cnt_load = cnt_load_q;
  assign cnt_in   = cnt_in_q;
  assign cnt_down = cnt_down_q;
  assign count    = count_q;
  assign halvings = halv_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_half_life_sequencer.sv
// Randomized and directed bench for half_life_sequencer against a cycle-level behavioural model.
module tb_half_life_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] init_val = '0;
  logic [3:0] period = '0;
  logic       tick = 1'b0;
  logic       cnt_load;
  logic [3:0] cnt_in;
  logic       cnt_down;
  logic [3:0] count;
  logic [2:0] halvings;
  logic       busy;
  logic       done;

  int tests = 0;
  int fails = 0;

  half_life_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .init_val (init_val),
    .period   (period),
    .tick     (tick),
    .cnt_load (cnt_load),
    .cnt_in   (cnt_in),
    .cnt_down (cnt_down),
    .count    (count),
    .halvings (halvings),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // Model phases: 0 idle, 1 loading, 2 waiting for ticks, 3 pulsing, 4 finishing.
  int m_ph = 0, m_per = 0, m_ticks = 0, m_left = 0, cnt_next = 0;
  int e_load = 0, e_in = 0, e_down = 0, e_count = 0, e_halv = 0, e_busy = 0, e_done = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph = 0; m_per = 0; m_ticks = 0; m_left = 0;
      e_load = 0; e_in = 0; e_down = 0; e_count = 0; e_halv = 0; e_busy = 0; e_done = 0;
    end else begin
      // what the external counter holds after this edge
      if (e_load != 0) cnt_next = e_in;
      else if (e_down != 0) cnt_next = e_count - 1;
      else cnt_next = e_count;

      if (abort && m_ph != 0) begin
        m_ph = 0; e_load = 0; e_down = 0; e_done = 0; e_busy = 0;
      end else if (m_ph == 0) begin
        if (start && !abort) begin
          e_in = int'(init_val);
          m_per = (period == 0) ? 1 : int'(period);
          m_ticks = 0; e_load = 1; e_busy = 1; m_ph = 1;
        end
      end else if (m_ph == 1) begin
        e_load = 0; e_halv = 0;
        if (e_in == 0) begin e_done = 1; m_ph = 4; end
        else m_ph = 2;
      end else if (m_ph == 2) begin
        if (tick) begin
          m_ticks++;
          if (m_ticks == m_per) begin
            m_ticks = 0;
            m_left = e_count - e_count / 2;
            e_down = 1; m_ph = 3;
          end
        end
      end else if (m_ph == 3) begin
        m_left--;
        if (m_left == 0) begin
          e_down = 0;
          e_halv = (e_halv + 1 > 7) ? 7 : e_halv + 1;
          if (cnt_next == 0) begin e_done = 1; m_ph = 4; end
          else m_ph = 2;
        end
      end else begin
        e_done = 0; e_busy = 0; m_ph = 0;
      end
      e_count = cnt_next;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cmp cnt_load", int'(cnt_load), e_load);
      chk("cmp cnt_in",   int'(cnt_in),   e_in);
      chk("cmp cnt_down", int'(cnt_down), e_down);
      chk("cmp count",    int'(count),    e_count);
      chk("cmp halvings", int'(halvings), e_halv);
      chk("cmp busy",     int'(busy),     e_busy);
      chk("cmp done",     int'(done),     e_done);
    end
  end

  // Burst lengths, done pulses and down pulses, accumulated over the whole run.
  int bursts[$];
  int cur_b = 0, done_total = 0, down_total = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (cnt_down) begin cur_b++; down_total++; end
      else if (cur_b != 0) begin bursts.push_back(cur_b); cur_b = 0; end
      if (done) done_total++;
    end
  end

  task automatic do_start(input logic [3:0] iv, input logic [3:0] pd);
    start = 1'b1; init_val = iv; period = pd;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_until_idle(input int every, input int budget, input string tag);
    int n = 0;
    while (busy && n < budget) begin
      tick = (every > 0) && ((n % every) == every - 1);
      n++;
      @(negedge clk);
    end
    tick = 1'b0;
    chk({tag, " idle within budget"}, int'(busy), 0);
  endtask

  int t1_exp[4] = '{6, 3, 2, 1};
  int sz0, dn0, dw0;

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    chk("reset cnt_load", int'(cnt_load), 0);
    chk("reset cnt_in", int'(cnt_in), 0);
    chk("reset cnt_down", int'(cnt_down), 0);
    chk("reset count", int'(count), 0);
    chk("reset halvings", int'(halvings), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 12 with period 2, tick every 4 cycles
    sz0 = bursts.size(); dn0 = done_total;
    do_start(4'd12, 4'd2);
    run_until_idle(4, 400, "t1");
    chk("t1 burst count", bursts.size() - sz0, 4);
    for (int i = 0; i < 4; i++)
      if (sz0 + i < bursts.size()) chk($sformatf("t1 burst %0d", i), bursts[sz0 + i], t1_exp[i]);
    chk("t1 halvings", int'(halvings), 4);
    chk("t1 count", int'(count), 0);
    chk("t1 done pulses", done_total - dn0, 1);

    // init_val = 0
    dw0 = down_total;
    do_start(4'd0, 4'd3);
    chk("t2 load cycle1", int'(cnt_load), 1);
    chk("t2 cnt_in cycle1", int'(cnt_in), 0);
    @(negedge clk);
    chk("t2 done cycle2", int'(done), 1);
    chk("t2 halvings cleared", int'(halvings), 0);
    @(negedge clk);
    chk("t2 busy cycle3", int'(busy), 0);
    chk("t2 no downs", down_total - dw0, 0);

    // period 0 acts as 1
    sz0 = bursts.size(); dn0 = done_total;
    do_start(4'd1, 4'd0);
    repeat (2) @(negedge clk);
    tick = 1'b1; @(negedge clk); tick = 1'b0;
    chk("t3 pulse after first tick", int'(cnt_down), 1);
    run_until_idle(0, 50, "t3");
    chk("t3 one burst", bursts.size() - sz0, 1);
    if (bursts.size() > sz0) chk("t3 burst len", bursts[sz0], 1);
    chk("t3 done pulses", done_total - dn0, 1);
    chk("t3 halvings", int'(halvings), 1);

    // abort on the second pulse of a 6-pulse burst
    dn0 = done_total;
    do_start(4'd12, 4'd1);
    @(negedge clk);
    tick = 1'b1; @(negedge clk); tick = 1'b0;
    chk("t4 pulse1", int'(cnt_down), 1);
    @(negedge clk);
    chk("t4 pulse2", int'(cnt_down), 1);
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    chk("t4 busy after abort", int'(busy), 0);
    chk("t4 down after abort", int'(cnt_down), 0);
    chk("t4 count after abort", int'(count), 10);
    repeat (5) @(negedge clk);
    chk("t4 count holds", int'(count), 10);
    chk("t4 no done", done_total - dn0, 0);

    // start during WAIT ignored; start+abort in IDLE ignored
    do_start(4'd8, 4'd3);
    @(negedge clk);
    start = 1'b1; init_val = 4'd5; period = 4'd1;
    @(negedge clk); start = 1'b0;
    chk("t5 no reload", int'(cnt_load), 0);
    chk("t5 cnt_in kept", int'(cnt_in), 8);
    tick = 1'b1; @(negedge clk); tick = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5 no pulse after 1 tick", int'(cnt_down), 0);
    tick = 1'b1; @(negedge clk); tick = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5 count after 2 ticks", int'(count), 8);
    tick = 1'b1; @(negedge clk); tick = 1'b0;
    chk("t5 pulse after 3 ticks", int'(cnt_down), 1);
    run_until_idle(3, 300, "t5");
    chk("t5 halvings", int'(halvings), 4);
    chk("t5 count", int'(count), 0);
    start = 1'b1; abort = 1'b1; init_val = 4'd9;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    chk("t5 start+abort busy", int'(busy), 0);
    chk("t5 start+abort load", int'(cnt_load), 0);
    chk("t5 start+abort cnt_in", int'(cnt_in), 8);

    // asynchronous reset mid-burst
    do_start(4'd12, 4'd1);
    @(negedge clk);
    tick = 1'b1; @(negedge clk); tick = 1'b0;
    chk("t6 in burst", int'(cnt_down), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6 async cnt_load", int'(cnt_load), 0);
    chk("t6 async cnt_in", int'(cnt_in), 0);
    chk("t6 async cnt_down", int'(cnt_down), 0);
    chk("t6 async count", int'(count), 0);
    chk("t6 async halvings", int'(halvings), 0);
    chk("t6 async busy", int'(busy), 0);
    chk("t6 async done", int'(done), 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6 stays idle", int'(busy), 0);
    chk("t6 no load", int'(cnt_load), 0);

    // randomized runs
    for (int r = 0; r < 40; r++) begin
      int n;
      int tp;
      tp = $urandom_range(1, 4);
      if ($urandom_range(0, 7) == 0) begin
        start = 1'b1; abort = 1'b1; init_val = 4'($urandom_range(0, 15));
        @(negedge clk); start = 1'b0; abort = 1'b0;
      end
      do_start(4'($urandom_range(0, 15)), 4'($urandom_range(0, 4)));
      n = 0;
      while (m_ph != 0 && n < 600) begin
        tick = ($urandom_range(1, tp) == 1);
        start = ($urandom_range(0, 9) == 0);
        init_val = 4'($urandom_range(0, 15));
        period = 4'($urandom_range(0, 4));
        abort = (m_ph == 2 || m_ph == 3) && ($urandom_range(0, 149) == 0);
        n++;
        @(negedge clk);
      end
      tick = 1'b0; start = 1'b0; abort = 1'b0;
      chk("rand run ends", m_ph, 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
